rx_capture_axi: RTL and testbench
=================================

// Module: rx_capture_axi
// PURPOSE
//  Multi-channel serial-receive capture engine behind the PS master AXI4 port (GP0), successor to the single-rx mkTop path.
//  Deserialises NUM_CH strobed bit streams into 32-bit words, buffers each channel in a DEPTH-word FIFO,
//  exposes control/status/pop windows over AXI4 (INCR/FIXED bursts, IDs) and raises a level irq to the PS.
// PARAMETERS
//  NUM_CH   4   number of rx channels, 1..8
//  DEPTH    16  words per channel FIFO, power of 2, 2..256
//  ID_W     12  AXI ID width (matches PS GP master)
//  ADDR_W   12  AXI address bits decoded (upper bits ignored)
// PORTS
//  CLK                    in   1        single clock for all logic
//  RST                    in   1        asynchronous, active-high reset
//  rx_en                  in   NUM_CH   per-channel bit strobe; rx_data[c] valid when rx_en[c]=1
//  rx_data                in   NUM_CH   per-channel serial bit
//  s_awvalid/s_awready    in/out 1      AW handshake
//  s_awaddr/awlen/awsize/awburst/awid  in ADDR_W/8/3/2/ID_W  write address channel
//  s_wvalid/s_wready      in/out 1      W handshake
//  s_wdata/s_wstrb/s_wlast in  32/4/1   write data channel
//  s_bvalid/s_bready      out/in 1      B handshake
//  s_bid/s_bresp          out  ID_W/2   write response
//  s_arvalid/s_arready    in/out 1      AR handshake
//  s_araddr/arlen/arsize/arburst/arid  in ADDR_W/8/3/2/ID_W  read address channel
//  s_rvalid/s_rready      out/in 1      R handshake
//  s_rdata/s_rid/s_rresp/s_rlast out 32/ID_W/2/1  read data channel
//  irq                    out  1        registered level interrupt to PS
// BEHAVIOUR
//  Reset: all outputs 0 except s_awready=s_arready=1; FIFOs empty, CTRL=0, STATUS=0, THRESH=0, shift counters 0.
//  Map: 0x000 CTRL [NUM_CH-1:0] ch enable, [8] irq_en, [9] flush (self-clearing, empties all FIFOs + shifters next cycle).
//   0x004 STATUS [NUM_CH-1:0] sticky overflow, W1C. 0x008 THRESH [8:0]. 0x010+4c LEVEL ch c (RO, 0..DEPTH).
//   0x100*(c+1) DATA ch c: each read beat pops one word. Unmapped: reads 0, writes dropped, resp OKAY.
//  Deserialiser: enabled ch c with rx_en[c]: bit k of word = k-th bit received (LSB first); 32nd bit pushes word.
//   Push when FIFO full: word dropped, STATUS[c] set. Disabling ch discards partial word (counter->0).
//  FIFO: push and pop same cycle always both succeed (incl. full and 1-entry); level unchanged. Pop of empty: rdata 0, rresp SLVERR.
//  Write FSM: W_IDLE (awready=1) -> AW hs: latch id/addr/len/burst -> W_DATA (wready=1) -> each beat applies wstrb lanes,
//   addr += 4 if INCR/WRAP, held if FIXED; beat count == awlen (wlast ignored) -> W_RESP (bvalid=1) -> B hs -> W_IDLE.
//   awsize != 2: all beats consumed, no register effect, bresp SLVERR.
//  Read FSM: R_IDLE (arready=1) -> AR hs -> R_DATA: rvalid rises the cycle after AR hs; each R hs advances addr as above;
//   rlast on beat arlen; after last hs -> R_IDLE. rdata/rresp held stable while rvalid & !rready. arsize != 2: beats 0, SLVERR, no pops.
//  Read and write FSMs independent; one outstanding transaction each. Same-cycle W1C and hardware set of STATUS: set wins.
//  Same-cycle CTRL flush and push: flush wins (FIFO empty after).
//  irq (1 cycle after cause): irq_en & (|STATUS | any enabled ch with THRESH!=0 and LEVEL>=THRESH).
//  RST asserted mid-burst: FSMs to IDLE immediately, valids drop, no B/R for the aborted transaction.
// TESTING
//  Ch0 enabled, 32 strobed bits 0xA5A5_0F0F LSB-first -> LEVEL0=1; single read of 0x100 -> rdata 0xA5A50F0F, OKAY, LEVEL0=0.
//  DEPTH+1 words into ch1, no reads -> LEVEL1=DEPTH, STATUS[1]=1, irq=1 with irq_en; write 0x2 to 0x004 -> STATUS 0, irq drops next cycle.
//  FIXED read burst arlen=3 at 0x200 with 2 words queued -> 2 OKAY beats of data, 2 SLVERR beats of 0, rlast on 4th, rid=arid.
//  INCR write burst arlen=2 at 0x000 (0x103, 0x0, 0x4) with wstrb=0x1 on beat 2 -> CTRL=0x103, STATUS unchanged, THRESH=4, bid=awid.
//  Ch2 full, push and DATA pop same cycle -> LEVEL2 stays DEPTH, no overflow; rready held low 5 cycles -> rdata stable.
//  RST pulse during 8-beat read burst -> rvalid 0 next edge, FIFOs empty, arready=1 after release.

Source files
------------

// File: rtl/rx_capture_axi_if.sv
// AXI4 slave-side bundle for the rx capture engine: AW/W/B and AR/R channels.
interface rx_capture_axi_if #(
  parameter int unsigned ID_W   = 12,
  parameter int unsigned ADDR_W = 12
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;

  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;

  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst, arid,
    input  arready,
    input  rvalid, rdata, rid, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid,
    output arready,
    output rvalid, rdata, rid, rresp, rlast,
    input  rready
  );
endinterface

// File: rtl/rx_capture_axi.sv
// Multi-channel serial capture: per-channel 32-bit deserialiser + FIFO, AXI4 register/pop windows,
// level interrupt on overflow or FIFO threshold.
module rx_capture_axi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ID_W   = 12,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] rx_en,
  input  logic [NUM_CH-1:0] rx_data,
  rx_capture_axi_if.slave   s,
  output logic              irq
);
  localparam int unsigned LW = $clog2(DEPTH);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'b00;

  typedef logic [LW-1:0] ptr_t;
  typedef logic [LW:0]   lvl_t;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  // Control/status registers
  logic [NUM_CH-1:0] ch_en_q, status_q;
  logic              irq_en_q, flush_q, irq_q;
  logic [8:0]        thresh_q;

  // Deserialisers and FIFOs
  logic [31:0] shreg_q [NUM_CH];
  logic [4:0]  cnt_q   [NUM_CH];
  logic [31:0] mem_q   [NUM_CH][DEPTH];
  ptr_t        wr_ptr_q [NUM_CH];
  ptr_t        rd_ptr_q [NUM_CH];
  lvl_t        level_q  [NUM_CH];
  logic [31:0] push_word [NUM_CH];
  logic [NUM_CH-1:0] push, push_ok, pop, pop_sel, ovf, thresh_hit, w1c;

  // Write channel
  w_state_e          w_state_q, w_state_d;
  logic [ADDR_W-1:0] w_addr_q, wa;
  logic [7:0]        w_len_q, w_beat_q;
  logic [1:0]        w_burst_q;
  logic [ID_W-1:0]   w_id_q;
  logic              w_size_err_q, aw_hs, w_hs;
  logic              reg_wr, wr_ctrl, wr_stat, wr_thr;

  // Read channel
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_next, rd_addr_sel, ra;
  logic [7:0]        r_len_q, r_beat_q;
  logic [1:0]        r_burst_q;
  logic [ID_W-1:0]   r_id_q;
  logic              r_size_err_q, rd_size_bad, load_en, r_last;
  logic [31:0]       rdata_q, rd_word;
  logic [1:0]        rresp_q;
  logic              rd_err;

  logic unused_bits;
  assign unused_bits = ^{s.wlast, s.wdata};

  always_comb begin
    push = '0;
    push_ok = '0;
    ovf = '0;
    thresh_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push[c]       = ch_en_q[c] & rx_en[c] & (cnt_q[c] == 5'd31) & ~flush_q;
      push_word[c]  = {rx_data[c], shreg_q[c][31:1]};
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      push_ok[c]    = push[c] & ((level_q[c] != lvl_t'(DEPTH)) | pop[c]);
      ovf[c]        = push[c] & ~push_ok[c];
      thresh_hit[c] = ch_en_q[c] & (thresh_q != 9'd0) & (9'(level_q[c]) >= thresh_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shreg_q[c]  <= '0;
        cnt_q[c]    <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        level_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush_q || !ch_en_q[c]) begin
          cnt_q[c] <= '0;
        end else if (rx_en[c]) begin
          shreg_q[c] <= push_word[c];
          cnt_q[c]   <= cnt_q[c] + 5'd1;
        end
        if (flush_q) begin
          wr_ptr_q[c] <= '0;
          rd_ptr_q[c] <= '0;
          level_q[c]  <= '0;
        end else begin
          if (push_ok[c]) wr_ptr_q[c] <= wr_ptr_q[c] + ptr_t'(1);
          if (pop[c])     rd_ptr_q[c] <= rd_ptr_q[c] + ptr_t'(1);
          level_q[c] <= level_q[c] + lvl_t'(push_ok[c]) - lvl_t'(pop[c]);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ok[c]) mem_q[c][wr_ptr_q[c]] <= push_word[c];
    end
  end

  // Register writes
  always_comb begin
    wa      = {w_addr_q[ADDR_W-1:2], 2'b00};
    reg_wr  = (w_state_q == WData) & s.wvalid & ~w_size_err_q;
    wr_ctrl = reg_wr & (wa == ADDR_W'(0));
    wr_stat = reg_wr & (wa == ADDR_W'(4));
    wr_thr  = reg_wr & (wa == ADDR_W'(8));
    w1c     = (wr_stat & s.wstrb[0]) ? s.wdata[NUM_CH-1:0] : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ch_en_q  <= '0;
      irq_en_q <= 1'b0;
      flush_q  <= 1'b0;
      status_q <= '0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      flush_q <= wr_ctrl & s.wstrb[1] & s.wdata[9];
      if (wr_ctrl & s.wstrb[0]) ch_en_q       <= s.wdata[NUM_CH-1:0];
      if (wr_ctrl & s.wstrb[1]) irq_en_q      <= s.wdata[8];
      if (wr_thr & s.wstrb[0])  thresh_q[7:0] <= s.wdata[7:0];
      if (wr_thr & s.wstrb[1])  thresh_q[8]   <= s.wdata[8];
      status_q <= (status_q & ~w1c) | ovf;
      irq_q    <= irq_en_q & ((|status_q) | (|thresh_hit));
    end
  end

  assign irq = irq_q;

  // Write FSM
  always_comb begin
    w_state_d = w_state_q;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    unique case (w_state_q)
      WIdle: if (s.awvalid) begin
        aw_hs     = 1'b1;
        w_state_d = WData;
      end
      WData: if (s.wvalid) begin
        w_hs = 1'b1;
        if (w_beat_q == w_len_q) w_state_d = WResp;
      end
      WResp: if (s.bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state_q    <= WIdle;
      w_addr_q     <= '0;
      w_len_q      <= '0;
      w_beat_q     <= '0;
      w_burst_q    <= '0;
      w_id_q       <= '0;
      w_size_err_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        w_addr_q     <= s.awaddr;
        w_len_q      <= s.awlen;
        w_burst_q    <= s.awburst;
        w_id_q       <= s.awid;
        w_size_err_q <= (s.awsize != 3'd2);
        w_beat_q     <= '0;
      end else if (w_hs) begin
        w_beat_q <= w_beat_q + 8'd1;
        if (w_burst_q != BurstFixed) w_addr_q <= w_addr_q + ADDR_W'(4);
      end
    end
  end

  assign s.awready = (w_state_q == WIdle);
  assign s.wready  = (w_state_q == WData);
  assign s.bvalid  = (w_state_q == WResp);
  assign s.bid     = w_id_q;
  assign s.bresp   = (s.bvalid && w_size_err_q) ? RespSlverr : RespOkay;

  // Read FSM: each beat is fetched (and its FIFO word popped) when it is loaded into rdata_q.
  always_comb begin
    r_state_d   = r_state_q;
    load_en     = 1'b0;
    r_addr_next = (r_burst_q == BurstFixed) ? r_addr_q : r_addr_q + ADDR_W'(4);
    r_last      = (r_beat_q == r_len_q);
    rd_addr_sel = r_addr_next;
    rd_size_bad = r_size_err_q;
    unique case (r_state_q)
      RIdle: begin
        rd_addr_sel = s.araddr;
        rd_size_bad = (s.arsize != 3'd2);
        if (s.arvalid) begin
          load_en   = 1'b1;
          r_state_d = RData;
        end
      end
      RData: if (s.rready) begin
        if (r_last) r_state_d = RIdle;
        else        load_en   = 1'b1;
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    ra      = {rd_addr_sel[ADDR_W-1:2], 2'b00};
    rd_word = '0;
    rd_err  = rd_size_bad;
    pop_sel = '0;
    if (!rd_size_bad) begin
      if (ra == ADDR_W'(0)) begin
        rd_word[NUM_CH-1:0] = ch_en_q;
        rd_word[8]          = irq_en_q;
        rd_word[9]          = flush_q;
      end else if (ra == ADDR_W'(4)) begin
        rd_word[NUM_CH-1:0] = status_q;
      end else if (ra == ADDR_W'(8)) begin
        rd_word[8:0] = thresh_q;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (ra == ADDR_W'(16 + 4 * c)) rd_word[LW:0] = level_q[c];
        if (ra == ADDR_W'(256 * (c + 1))) begin
          if (level_q[c] != '0) begin
            rd_word    = mem_q[c][rd_ptr_q[c]];
            pop_sel[c] = 1'b1;
          end else begin
            rd_err = 1'b1;
          end
        end
      end
    end
    pop = load_en ? pop_sel : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state_q    <= RIdle;
      r_addr_q     <= '0;
      r_len_q      <= '0;
      r_beat_q     <= '0;
      r_burst_q    <= '0;
      r_id_q       <= '0;
      r_size_err_q <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RespOkay;
    end else begin
      r_state_q <= r_state_d;
      if (load_en) begin
        if (r_state_q == RIdle) begin
          r_addr_q     <= s.araddr;
          r_len_q      <= s.arlen;
          r_burst_q    <= s.arburst;
          r_id_q       <= s.arid;
          r_size_err_q <= (s.arsize != 3'd2);
          r_beat_q     <= '0;
        end else begin
          r_addr_q <= r_addr_next;
          r_beat_q <= r_beat_q + 8'd1;
        end
        rdata_q <= rd_word;
        rresp_q <= rd_err ? RespSlverr : RespOkay;
      end
    end
  end

  assign s.arready = (r_state_q == RIdle);
  assign s.rvalid  = (r_state_q == RData);
  assign s.rlast   = s.rvalid & r_last;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.rid     = r_id_q;
endmodule

// File: tb/tb_rx_capture_axi.sv
// Directed-plus-random bench for rx_capture_axi against a queue-based model of the register map.
module tb_rx_capture_axi;
  localparam int NCH = 4;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] rx_en = '0;
  logic [NCH-1:0] rx_data = '0;
  logic irq;

  always #5 clk = ~clk;

  rx_capture_axi_if #(.ID_W(12), .ADDR_W(12)) bus ();

  rx_capture_axi #(.NUM_CH(NCH), .DEPTH(DEP), .ID_W(12), .ADDR_W(12)) dut (
    .CLK    (clk),
    .RST    (rst),
    .rx_en  (rx_en),
    .rx_data(rx_data),
    .s      (bus.slave),
    .irq    (irq)
  );

  // Reference model
  logic [31:0] mq [NCH][$];
  logic [NCH-1:0] m_en, m_status;
  logic m_irq_en;
  logic [8:0] m_thresh;
  int total = 0;
  int bad = 0;
  logic [31:0] wd [4];
  logic [3:0]  ws [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_en = '0;
    m_status = '0;
    m_irq_en = 1'b0;
    m_thresh = '0;
  endtask

  task automatic model_push(input int c, input logic [31:0] w);
    if (m_en[c]) begin
      if (mq[c].size() == DEP) m_status[c] = 1'b1;
      else mq[c].push_back(w);
    end
  endtask

  function automatic logic model_irq();
    logic hit = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (m_en[c] && m_thresh != 0 && mq[c].size() >= int'(m_thresh)) hit = 1'b1;
    return m_irq_en && ((m_status != 0) || hit);
  endfunction

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    logic [11:0] aw;
    aw = {a[11:2], 2'b00};
    d = '0;
    r = 2'b00;
    if (aw == 12'h000) begin
      d[NCH-1:0] = m_en;
      d[8] = m_irq_en;
    end else if (aw == 12'h004) begin
      d[NCH-1:0] = m_status;
    end else if (aw == 12'h008) begin
      d[8:0] = m_thresh;
    end
    for (int c = 0; c < NCH; c++) begin
      if (int'(aw) == 16 + 4 * c) d = mq[c].size();
      if (int'(aw) == 256 * (c + 1)) begin
        if (mq[c].size() > 0) d = mq[c].pop_front();
        else r = 2'b10;
      end
    end
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st);
    logic [11:0] aw;
    aw = {a[11:2], 2'b00};
    if (aw == 12'h000) begin
      if (st[0]) m_en = d[NCH-1:0];
      if (st[1]) begin
        m_irq_en = d[8];
        if (d[9]) for (int c = 0; c < NCH; c++) mq[c].delete();
      end
    end else if (aw == 12'h004) begin
      if (st[0]) m_status = m_status & ~d[NCH-1:0];
    end else if (aw == 12'h008) begin
      if (st[0]) m_thresh[7:0] = d[7:0];
      if (st[1]) m_thresh[8] = d[8];
    end
  endtask

  task automatic send_word(input int c, input logic [31:0] w);
    for (int k = 0; k < 32; k++) begin
      rx_en[c] = 1'b1;
      rx_data[c] = w[k];
      tick();
      rx_en[c] = 1'b0;
      rx_data[c] = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    model_push(c, w);
    tick();
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
    logic [11:0] a, id;
    int n;
    a = addr;
    id = 12'($urandom);
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awid = id;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 100) begin tick(); n++; end
    if (n >= 100) tmo("aw_wait");
    tick();
    bus.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wdata = wd[b % 4]; bus.wstrb = ws[b % 4]; bus.wlast = (b == int'(len));
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 100) begin tick(); n++; end
      if (n >= 100) tmo("w_wait");
      tick();
      if (size == 3'd2) model_write(a, wd[b % 4], ws[b % 4]);
      if (burst != 2'b00) a = a + 12'd4;
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 100) begin tick(); n++; end
    if (n >= 100) tmo("b_wait");
    chk("bresp", bus.bresp, (size == 3'd2) ? 2'b00 : 2'b10);
    chk("bid", bus.bid, id);
    tick();
    bus.bready = 1'b0;
    tick();
    tick();
  endtask

  task automatic wr1(input logic [11:0] addr, input logic [31:0] d);
    wd[0] = d;
    ws[0] = 4'hF;
    axi_write(addr, 8'd0, 3'd2, 2'b01);
  endtask

  task automatic axi_read(input logic [11:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int hold);
    logic [11:0] a, id;
    logic [31:0] ed;
    logic [1:0] er;
    int n;
    a = addr;
    id = 12'($urandom);
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 100) begin tick(); n++; end
    if (n >= 100) tmo("ar_wait");
    tick();
    bus.arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!bus.rvalid && n < 100) begin tick(); n++; end
      if (n >= 100) tmo("r_wait");
      if (size != 3'd2) begin ed = '0; er = 2'b10; end
      else model_read(a, ed, er);
      for (int h = 0; h < hold; h++) begin
        chk("rdata_hold", bus.rdata, ed);
        tick();
      end
      bus.rready = 1'b1;
      chk("rdata", bus.rdata, ed);
      chk("rresp", bus.rresp, er);
      chk("rlast", bus.rlast, (b == int'(len)));
      chk("rid", bus.rid, id);
      tick();
      bus.rready = 1'b0;
      if (burst != 2'b00) a = a + 12'd4;
    end
    chk("r_done", bus.rvalid, 1'b0);
    tick();
  endtask

  initial begin
    logic [31:0] w, ed;
    logic [1:0] er;
    logic [11:0] id;
    int n, op, c;

    bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0; bus.awid = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0; bus.arid = 0;
    bus.rready = 0;
    model_reset();
    tick();
    tick();
    chk("rst_awready", bus.awready, 1'b1);
    chk("rst_arready", bus.arready, 1'b1);
    chk("rst_wready", bus.wready, 1'b0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    rst = 1'b0;
    tick();
    axi_read(12'h000, 8'd2, 3'd2, 2'b01, 0);

    // Single word on ch0, LSB first
    wr1(12'h000, 32'h1);
    send_word(0, 32'hA5A5_0F0F);
    axi_read(12'h010, 8'd0, 3'd2, 2'b01, 0);
    axi_read(12'h100, 8'd0, 3'd2, 2'b01, 0);
    axi_read(12'h010, 8'd0, 3'd2, 2'b01, 0);

    // Overflow on ch1
    wr1(12'h000, 32'h103);
    for (int i = 0; i < DEP + 1; i++) send_word(1, $urandom);
    axi_read(12'h014, 8'd0, 3'd2, 2'b01, 0);
    axi_read(12'h004, 8'd0, 3'd2, 2'b01, 0);
    chk("irq_ovf", irq, 1'b1);
    wr1(12'h004, 32'h2);
    chk("irq_w1c", irq, 1'b0);
    axi_read(12'h004, 8'd0, 3'd2, 2'b01, 0);

    // FIXED burst beyond available data
    wr1(12'h000, 32'h303);
    send_word(1, $urandom);
    send_word(1, $urandom);
    axi_read(12'h200, 8'd3, 3'd2, 2'b00, 1);

    // INCR write burst with partial strobe on last beat
    wd[0] = 32'h103; ws[0] = 4'hF;
    wd[1] = 32'h0;   ws[1] = 4'hF;
    wd[2] = 32'h4;   ws[2] = 4'h1;
    axi_write(12'h000, 8'd2, 3'd2, 2'b01);
    axi_read(12'h000, 8'd2, 3'd2, 2'b01, 0);

    // Random traffic
    wr1(12'h000, 32'h10F);
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 8);
      c = $urandom_range(0, NCH - 1);
      case (op)
        0, 1, 2: send_word(c, $urandom);
        3: axi_read(12'((c + 1) * 256), 8'($urandom_range(0, 3)), 3'd2, 2'b00, $urandom_range(0, 2));
        4: axi_read(12'h010, 8'd3, 3'd2, 2'b01, 0);
        5: wr1(12'h004, 32'($urandom_range(0, 15)));
        6: wr1(12'h008, 32'($urandom_range(0, DEP + 1)));
        7: begin
          wd[0] = $urandom; ws[0] = 4'hF; wd[1] = $urandom; ws[1] = 4'hF;
          axi_write(12'h000, 8'd1, 3'd1, 2'b01);
        end
        default: axi_read(12'((c + 1) * 256), 8'd1, 3'd1, 2'b00, 0);
      endcase
      tick();
      tick();
      chk("irq_rand", irq, model_irq());
    end
    axi_read(12'h000, 8'd2, 3'd2, 2'b01, 0);

    // Push into a full FIFO in the same cycle as a pop
    wr1(12'h000, 32'h30F);
    wr1(12'h004, 32'hF);
    for (int i = 0; i < DEP; i++) send_word(2, $urandom);
    w = $urandom;
    for (int k = 0; k < 31; k++) begin
      rx_en[2] = 1'b1;
      rx_data[2] = w[k];
      tick();
    end
    id = 12'($urandom);
    bus.araddr = 12'h300; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = id;
    bus.arvalid = 1'b1;
    rx_data[2] = w[31];
    chk("same_arready", bus.arready, 1'b1);
    tick();
    bus.arvalid = 1'b0;
    rx_en[2] = 1'b0;
    ed = mq[2].pop_front();
    model_push(2, w);
    n = 0;
    while (!bus.rvalid && n < 100) begin tick(); n++; end
    if (n >= 100) tmo("same_r_wait");
    for (int h = 0; h < 5; h++) begin
      chk("same_rdata_hold", bus.rdata, ed);
      tick();
    end
    bus.rready = 1'b1;
    chk("same_rdata", bus.rdata, ed);
    chk("same_rresp", bus.rresp, 2'b00);
    chk("same_rlast", bus.rlast, 1'b1);
    chk("same_rid", bus.rid, id);
    tick();
    bus.rready = 1'b0;
    tick();
    axi_read(12'h004, 8'd0, 3'd2, 2'b01, 0);
    axi_read(12'h018, 8'd0, 3'd2, 2'b01, 0);
    axi_read(12'h300, 8'(DEP - 1), 3'd2, 2'b00, 0);

    // Reset in the middle of an 8-beat read burst
    for (int i = 0; i < 3; i++) send_word(3, $urandom);
    id = 12'($urandom);
    bus.araddr = 12'h400; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = 2'b00; bus.arid = id;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (!bus.rvalid && n < 100) begin tick(); n++; end
      if (n >= 100) tmo("rst_r_wait");
      model_read(12'h400, ed, er);
      bus.rready = 1'b1;
      chk("rst_burst_rdata", bus.rdata, ed);
      chk("rst_burst_rresp", bus.rresp, er);
      tick();
      bus.rready = 1'b0;
    end
    chk("rvalid_pre_rst", bus.rvalid, 1'b1);
    rst = 1'b1;
    tick();
    chk("rvalid_in_rst", bus.rvalid, 1'b0);
    chk("bvalid_in_rst", bus.bvalid, 1'b0);
    rst = 1'b0;
    model_reset();
    tick();
    chk("arready_after_rst", bus.arready, 1'b1);
    chk("irq_after_rst", irq, 1'b0);
    axi_read(12'h010, 8'd3, 3'd2, 2'b01, 0);
    axi_read(12'h000, 8'd2, 3'd2, 2'b01, 0);
    axi_read(12'h400, 8'd0, 3'd2, 2'b01, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
